// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } sched_state_t;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         CNT_W_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// Event counter with async clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline stall/flush arbiter: load-use, ID redirects and data-memory wait.
// Define HAZARD_PERF_CNT_EN to add the stall/flush performance counters.
module hazard_scheduler
    import pipeline_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              pipe_freeze_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    sched_state_t state_q;
    sched_state_t state_d;

    logic mem_stall;
    logic load_use;
    logic stall_evt;

    assign mem_stall = mem_req_i && !mem_ack_i;
    assign load_use  = idex_memread_i
                    && (idex_rt_i != REG_AW'(REG_ZERO))
                    && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b1;
        stall_evt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (!start_i)      state_d = IDLE;
                else if (mem_stall) state_d = MEM_WAIT;
                // Load-use wins over redirects: the branch is retried once operands arrive.
                if (!mem_stall) begin
                    pipe_freeze_o = 1'b0;
                    if (load_use) begin
                        idex_bubble_o = 1'b1;
                        stall_evt     = 1'b1;
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                        ifid_flush_o = branch_taken_i || jump_i;
                    end
                end
            end
            MEM_WAIT: begin
                if (!start_i)      state_d = IDLE;
                else if (mem_ack_i) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_evt),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (ifid_flush_o),
        .cnt_o (flush_cnt_o)
    );
`else
    logic unused_stall;
    assign unused_stall = stall_evt;
`endif

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline sequencing controller for the 5-stage MIPS CPU. It arbitrates pipeline-register and PC write permission between three stall/flush sources: load-use hazards, ID-stage branch/jump redirects, and a multi-cycle data-memory handshake. It drives PC, IF/ID, ID/EX and the back-end registers, and optionally maintains stall/flush performance counters for the bench.

## Interface
Parameters:
- CNT_W, 32, width of performance counters
- REG_AW, 5, register address width

Ports:
- clk_i  in  1  pipeline clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  run enable from CPU top
- idex_memread_i  in  1  instruction in EX is a load
- idex_rt_i  in  REG_AW  load destination in EX
- ifid_rs_i, ifid_rt_i  in  REG_AW  source registers of the instruction in ID
- branch_taken_i  in  1  branch resolved taken in ID
- jump_i  in  1  jump decoded in ID
- mem_req_i  in  1  EX/MEM stage accesses data memory this cycle
- mem_ack_i  in  1  data memory completes access
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID loads NOP
- idex_bubble_o  out  1  ID/EX loads all-zero control
- pipe_freeze_o  out  1  ID/EX, EX/MEM and MEM/WB hold
- stall_cnt_o  out  CNT_W  load-use stall cycles (macro only)
- flush_cnt_o  out  CNT_W  flush cycles (macro only)

## Operation
- FSM states: IDLE, RUN, MEM_WAIT.
- IDLE: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0, pipe_freeze_o=1. Transitions to RUN when start_i=1.
- RUN, evaluated in priority order:
  1. If mem_req_i=1 and mem_ack_i=0: all outputs as IDLE; next state is MEM_WAIT.
  2. Load-use hazard: idex_memread_i=1, idex_rt_i!=0, and idex_rt_i equals ifid_rs_i or ifid_rt_i. Then pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. A branch or jump in ID is ignored this cycle and re-evaluated once its operands are ready.
  3. branch_taken_i or jump_i: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1.
  4. Otherwise pc_write_o=1, ifid_write_o=1, with all other outputs 0.
- MEM_WAIT: outputs are identical to IDLE. Transitions to RUN on the cycle mem_ack_i=1; that cycle's outputs are still frozen.
- If mem_req_i and mem_ack_i are both 1 in RUN, there is no wait and rules 2–4 apply.
- start_i=0 in RUN or MEM_WAIT forces IDLE at the next edge. A pending memory access is abandoned.
- All outputs are combinational from the state register and inputs. Only the state and counters are registered.

## Timing
- Reset (asynchronous): state=IDLE, counters=0. During reset, outputs take their IDLE values.
- Start latency: the edge that samples start_i=1 enters RUN. The first PC advance happens on the following edge.
- A load-use stall lasts exactly 1 cycle, because the inserted bubble clears idex_memread_i.
- A memory wait of N cycles between mem_req_i rising and mem_ack_i gives N+1 frozen cycles.
- Counters update on the rising edge, in the same cycle as the condition, and saturate at all-ones (no wrap).
  - stall_cnt_o counts rule-2 cycles only.
  - flush_cnt_o counts cycles with ifid_flush_o=1.
- Reset asserted mid-wait or mid-stall returns to IDLE immediately. The counters clear.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt_o and flush_cnt_o ports and counters are present.
- Not defined: ports and counters are absent, and control behaviour is identical.

## Structure
- Shared package pipeline_pkg holds:
  - sched_state_t enum (IDLE, RUN, MEM_WAIT)
  - REG_ZERO constant (5'd0)
  - CNT_W default
- One sub-module, sat_counter (enable, async clear, saturate at max), instantiated twice under the macro.

## Test plan
- Reset, then start_i=1 with no hazards: one cycle of pc_write_o=0, then pc_write_o=1 continuously. Counters stay 0.
- lw $t0 in EX, add using $t0 in ID: exactly 1 cycle of idex_bubble_o=1 with pc_write_o=0. stall_cnt_o=1.
- idex_rt_i=0 with idex_memread_i=1 and matching ifid_rs_i=0: no stall.
- Load-use and branch_taken_i in the same cycle: stall only (flush_cnt_o unchanged). On the next cycle with branch_taken_i=1, ifid_flush_o=1 and flush_cnt_o=1.
- mem_req_i held, mem_ack_i after 3 cycles: pipe_freeze_o=1 for 4 cycles, then RUN. rst_i pulsed during a second wait: IDLE immediately, counters 0.
- Force stall_cnt_o to all-ones, then trigger a further stall: value holds at all-ones.
